// File: rtl/case_5_mac_accum.sv
// Accumulates LEN signed products per result with valid/ready on both sides.
// Optional feature macro CASE_5_ACC_SAT_EN: saturate out_data on overflow (default: wrap).
module case_5_mac_accum #(
    parameter int IN_WIDTH  = 12,
    parameter int ACC_WIDTH = 24,
    parameter int OUT_WIDTH = 16,
    parameter int LEN       = 8,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 acc_clr,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_ovf,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [ACC_WIDTH-1:0]   acc_reg, acc_next;
    logic [CNT_WIDTH-1:0]   cnt_reg, cnt_next;
    logic [OUT_WIDTH-1:0]   out_data_reg, out_data_next;
    logic                   out_ovf_reg, out_ovf_next;

    logic [ACC_WIDTH-1:0]   in_ext;
    logic [ACC_WIDTH-1:0]   acc_base;
    logic [ACC_WIDTH-1:0]   sum;
    logic                   sum_ovf;
    logic [OUT_WIDTH-1:0]   sum_out;
    logic                   accept;
    logic                   transfer;
    logic                   valid_next;

    assign in_ext   = {{(ACC_WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
    // A fresh result starts from zero, so the stale accumulator never leaks in.
    assign acc_base = (cnt_reg == '0) ? '0 : acc_reg;
    assign sum      = acc_base + in_ext;

    // Representable in OUT_WIDTH iff all bits from the OUT_WIDTH sign bit upward agree.
    assign sum_ovf  = !((&sum[ACC_WIDTH-1:OUT_WIDTH-1]) || !(|sum[ACC_WIDTH-1:OUT_WIDTH-1]));

`ifdef CASE_5_ACC_SAT_EN
    assign sum_out = !sum_ovf ? sum[OUT_WIDTH-1:0] :
                     sum[ACC_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                      : {1'b0, {(OUT_WIDTH-1){1'b1}}};
`else
    assign sum_out = sum[OUT_WIDTH-1:0];
`endif

    assign out_valid = (state_reg == HOLD);
    assign in_ready  = !acc_clr && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign transfer  = out_valid && out_ready;
    assign out_data  = out_data_reg;
    assign out_ovf   = out_ovf_reg;
    assign busy      = (cnt_reg != '0);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_reg    <= IDLE;
            acc_reg      <= '0;
            cnt_reg      <= '0;
            out_data_reg <= '0;
            out_ovf_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            acc_reg      <= acc_next;
            cnt_reg      <= cnt_next;
            out_data_reg <= out_data_next;
            out_ovf_reg  <= out_ovf_next;
        end
    end

    always_comb begin
        acc_next      = acc_reg;
        cnt_next      = cnt_reg;
        out_data_next = out_data_reg;
        out_ovf_next  = out_ovf_reg;
        valid_next    = out_valid;

        if (transfer) begin
            valid_next = 1'b0;
        end

        if (acc_clr) begin
            cnt_next = '0;
            acc_next = '0;
        end else if (accept) begin
            if (cnt_reg == CNT_WIDTH'(LEN-1)) begin
                cnt_next      = '0;
                acc_next      = '0;
                out_data_next = sum_out;
                out_ovf_next  = sum_ovf;
                valid_next    = 1'b1;
            end else begin
                acc_next = sum;
                cnt_next = cnt_reg + CNT_WIDTH'(1);
            end
        end

        // HOLD takes priority: accumulation may continue underneath a pending result.
        if (valid_next) begin
            state_next = HOLD;
        end else if (cnt_next != '0) begin
            state_next = ACCUM;
        end else begin
            state_next = IDLE;
        end
    end

endmodule

// File: tb/tb_case_5_mac_accum.sv
// Scoreboard bench: a sample-list reference model drives two DUTs (OUT_WIDTH 16 and 12) with shared stimulus.
module tb_case_5_mac_accum;
    localparam int IW  = 12;
    localparam int LEN = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [IW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          acc_clr = 1'b0;
    logic          out_ready = 1'b0;

    logic          in_ready_a, out_valid_a, out_ovf_a, busy_a;
    logic [15:0]   out_data_a;
    logic          in_ready_b, out_valid_b, out_ovf_b, busy_b;
    logic [11:0]   out_data_b;

    always #5 clk = ~clk;

    case_5_mac_accum #(.IN_WIDTH(12), .ACC_WIDTH(24), .OUT_WIDTH(16), .LEN(8), .CNT_WIDTH(4)) u_dut_a (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_a),
        .acc_clr(acc_clr), .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready),
        .out_ovf(out_ovf_a), .busy(busy_a));

    case_5_mac_accum #(.IN_WIDTH(12), .ACC_WIDTH(24), .OUT_WIDTH(12), .LEN(8), .CNT_WIDTH(4)) u_dut_b (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready_b),
        .acc_clr(acc_clr), .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready),
        .out_ovf(out_ovf_b), .busy(busy_b));

    typedef struct {
        longint data;
        bit     ovf;
    } exp_t;

    exp_t   q_a[$];
    exp_t   q_b[$];
    longint part[$];
    bit     pending = 1'b0;
    int     vectors = 0;
    int     miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t expect_of(input longint sum, input int w);
        exp_t   r;
        longint mx;
        longint mn;
        longint mask;
        mx    = (longint'(1) << (w-1)) - 1;
        mn    = -(longint'(1) << (w-1));
        mask  = (longint'(1) << w) - 1;
        r.ovf = (sum > mx) || (sum < mn);
`ifdef CASE_5_ACC_SAT_EN
        r.data = ((sum > mx) ? mx : (sum < mn) ? mn : sum) & mask;
`else
        r.data = sum & mask;
`endif
        return r;
    endfunction

    // Monitor and reference model: compare what the DUTs present, then advance the model past the edge.
    always @(negedge clk) begin
        bit     exp_ir;
        longint s;
        exp_t   e;
        if (!rst_n) begin
            part.delete();
            q_a.delete();
            q_b.delete();
            pending = 1'b0;
        end else begin
            exp_ir = !acc_clr && (!pending || out_ready);
            check("in_ready_a", {63'd0, in_ready_a}, {63'd0, exp_ir});
            check("in_ready_b", {63'd0, in_ready_b}, {63'd0, exp_ir});
            check("out_valid_a", {63'd0, out_valid_a}, {63'd0, pending});
            check("out_valid_b", {63'd0, out_valid_b}, {63'd0, pending});
            check("busy_a", {63'd0, busy_a}, {63'd0, part.size() != 0});
            check("busy_b", {63'd0, busy_b}, {63'd0, part.size() != 0});

            if (out_valid_a && out_ready) begin
                if (q_a.size() == 0) check("unexpected_result_a", 64'd1, 64'd0);
                else begin
                    e = q_a.pop_front();
                    check("out_data_a", {48'd0, out_data_a}, e.data);
                    check("out_ovf_a", {63'd0, out_ovf_a}, {63'd0, e.ovf});
                    $display("result16 data=0x%04h ovf=%0d", out_data_a, out_ovf_a);
                end
            end
            if (out_valid_b && out_ready) begin
                if (q_b.size() == 0) check("unexpected_result_b", 64'd1, 64'd0);
                else begin
                    e = q_b.pop_front();
                    check("out_data_b", {52'd0, out_data_b}, e.data);
                    check("out_ovf_b", {63'd0, out_ovf_b}, {63'd0, e.ovf});
                    $display("result12 data=0x%03h ovf=%0d", out_data_b, out_ovf_b);
                end
            end

            if (pending && out_ready) pending = 1'b0;
            if (acc_clr) begin
                part.delete();
            end else if (in_valid && exp_ir) begin
                part.push_back(longint'($signed(in_data)));
                if (part.size() == LEN) begin
                    s = 0;
                    foreach (part[i]) s += part[i];
                    q_a.push_back(expect_of(s, 16));
                    q_b.push_back(expect_of(s, 12));
                    pending = 1'b1;
                    part.delete();
                end
            end
        end
    end

    task automatic cyc(input bit v, input logic [IW-1:0] d, input bit clr, input bit rdy);
        in_valid  = v;
        in_data   = d;
        acc_clr   = clr;
        out_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic burst(input int n, input logic [IW-1:0] d, input bit rdy);
        for (int i = 0; i < n; i++) cyc(1'b1, d, 1'b0, rdy);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_out_valid_a"}, {63'd0, out_valid_a}, 64'd0);
        check({tag, "_out_data_a"}, {48'd0, out_data_a}, 64'd0);
        check({tag, "_out_ovf_a"}, {63'd0, out_ovf_a}, 64'd0);
        check({tag, "_busy_a"}, {63'd0, busy_a}, 64'd0);
        check({tag, "_out_valid_b"}, {63'd0, out_valid_b}, 64'd0);
        check({tag, "_out_data_b"}, {52'd0, out_data_b}, 64'd0);
        check({tag, "_out_ovf_b"}, {63'd0, out_ovf_b}, 64'd0);
        check({tag, "_busy_b"}, {63'd0, busy_b}, 64'd0);
    endtask

    initial begin
        logic [IW-1:0] d;
        #1;
        check_zero_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Back-to-back 1..8 gives 36.
        for (int i = 1; i <= 8; i++) cyc(1'b1, IW'(i), 1'b0, 1'b1);
        idle(2);

        // 8 x 2047: fits in 16 bits, overflows 12 bits.
        burst(8, 12'h7FF, 1'b1);
        idle(2);

        // Backpressure for 10 cycles, then transfer and accept together.
        burst(8, 12'd3, 1'b1);
        burst(10, 12'd7, 1'b0);
        burst(8, 12'd7, 1'b1);
        idle(2);

        // Partial sum dropped by acc_clr.
        burst(3, 12'd9, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b1);
        burst(8, 12'd5, 1'b1);
        idle(2);

        // Asynchronous reset mid-accumulation.
        burst(5, 12'd4, 1'b1);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_zero_outputs("midreset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        burst(8, 12'hFFF, 1'b1);
        idle(2);

        // Two back-to-back results at the negative extreme.
        burst(16, 12'h800, 1'b1);
        idle(2);

        // Randomized traffic with occasional clears and extreme values.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0:       d = 12'h7FF;
                1:       d = 12'h800;
                default: d = IW'($urandom);
            endcase
            cyc(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0));
        end
        idle(3);

        check("q_a_drained", 64'(q_a.size()), 64'd0);
        check("q_b_drained", 64'(q_b.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
